// File: rtl/game_sequencer_pkg.sv
// Shared types, screen defaults and helpers for the game-flow controller
// and the blocks that consume its state (doodle, platforms, tabloid, painter).
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    RESPAWN = 3'd2,
    PAUSED  = 3'd3,
    OVER    = 3'd4
  } game_state_t;

  localparam int EARTH_DEF         = 768;
  localparam int DOODLE_HEIGHT_DEF = 80;

  // Unsigned add that clamps at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    if (w >= 32) lim = {1'b0, 32'hFFFF_FFFF};
    else         lim = (33'd1 << w) - 33'd1;
    if (sum > lim) sum = lim;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the game sequencer and its surroundings: button levels and
// world feedback in, frame timing, game state and scoring out.
// slave = the sequencer itself, master = whoever drives the buttons/world.
interface game_sequencer_if #(
  parameter int SCORE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 9
);
  import game_sequencer_pkg::*;

  logic                   start;
  logic                   pause_toggle;
  logic [9:0]             doodle_y;
  logic                   move_collision;
  logic [SHIFT_WIDTH-1:0] shift_amount;

  logic                   frame_tick;
  game_state_t            game_state;
  logic                   freeze;
  logic                   respawn;
  logic [3:0]             lives;
  logic [SCORE_WIDTH-1:0] score;
  logic [SCORE_WIDTH-1:0] high_score;

  modport master (
    output start, pause_toggle, doodle_y, move_collision, shift_amount,
    input  frame_tick, game_state, freeze, respawn, lives, score, high_score
  );

  modport slave (
    input  start, pause_toggle, doodle_y, move_collision, shift_amount,
    output frame_tick, game_state, freeze, respawn, lives, score, high_score
  );

endinterface

// File: rtl/game_sequencer_frame_ticker.sv
// Free-running frame-rate divider: one-cycle frame_tick_o every CLK/FPS cycles.
// Shared by every block that steps once per frame.
module frame_ticker #(
  parameter int CLK = 50000000,
  parameter int FPS = 360
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick_o
);

  localparam int TICK_DIV = CLK / FPS;
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;

  // Counter wraps from TICK_DIV-1 back to zero.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Tick is registered, so it appears the cycle after the counter hits LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == LAST);
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: frame ticks, multi-life game FSM, score and high score.
// Optional feature macro: GAME_PAUSE_EN (adds the PAUSED state and the
// pause_toggle edge detector; without it pause_toggle is ignored).
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int CLK            = 50000000,
  parameter int FPS            = 360,
  parameter int EARTH          = EARTH_DEF,
  parameter int DOODLE_HEIGHT  = DOODLE_HEIGHT_DEF,
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 180,
  parameter int SCORE_WIDTH    = 16,
  parameter int SHIFT_WIDTH    = 9
) (
  input  logic            clk,
  input  logic            rst,
  game_sequencer_if.slave bus
);

  localparam logic [9:0] FALL_Y = 10'(EARTH - DOODLE_HEIGHT);
  localparam int RW = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [RW-1:0] R_LAST     = RW'(RESPAWN_FRAMES - 1);
  localparam logic [3:0]    LIVES_INIT = 4'(LIVES);

  logic frame_tick;

  frame_ticker #(
    .CLK (CLK),
    .FPS (FPS)
  ) u_ticker (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_o (frame_tick)
  );

  game_state_t            state_q, state_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic [3:0]             lives_q, lives_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [SCORE_WIDTH-1:0] hs_q, hs_d;
  logic                   freeze_q, freeze_d;
  logic                   respawn_q, respawn_d;
  logic                   start_q;
  logic                   start_ev;
  logic                   pause_ev;
  logic                   restart;
  logic                   falling;

  assign start_ev = bus.start & ~start_q;
  assign falling  = (bus.doodle_y >= FALL_Y);

`ifdef GAME_PAUSE_EN
  logic pause_q;

  // Previous pause button level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pause_q <= 1'b0;
    else     pause_q <= bus.pause_toggle;
  end

  assign pause_ev = bus.pause_toggle & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = bus.pause_toggle;
  assign pause_ev     = 1'b0;
`endif

  // State, counters, edge register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      lives_q   <= LIVES_INIT;
      score_q   <= '0;
      hs_q      <= '0;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      hs_q      <= hs_d;
      freeze_q  <= freeze_d;
      respawn_q <= respawn_d;
      start_q   <= bus.start;
    end
  end

  // Next state: buttons act on any cycle, fall/respawn timing only on frame ticks.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (start_ev) state_d = PLAY;
      end
      PLAY: begin
        rcnt_d = '0;
        if (pause_ev)                   state_d = PAUSED;
        else if (frame_tick && falling) state_d = (lives_q > 4'd1) ? RESPAWN : OVER;
      end
      RESPAWN: begin
        if (frame_tick) begin
          if (rcnt_q == R_LAST) begin
            state_d = PLAY;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      PAUSED: begin
        if (pause_ev) state_d = PLAY;
      end
      OVER: begin
        if (start_ev) state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values derived from the current and next state.
  always_comb begin
    restart   = start_ev && ((state_q == IDLE) || (state_q == OVER));
    freeze_d  = (state_d != PLAY);
    respawn_d = restart || ((state_q == RESPAWN) && (state_d == PLAY));
    lives_d   = lives_q;
    score_d   = score_q;
    hs_d      = hs_q;
    // Score is stable throughout OVER, so refreshing every OVER cycle equals
    // capturing it on entry.
    if ((state_q == OVER) && (score_q > hs_q)) hs_d = score_q;
    if (restart) begin
      lives_d = LIVES_INIT;
      score_d = '0;
    end else if (state_q == PLAY) begin
      if (state_d == RESPAWN)   lives_d = lives_q - 4'd1;
      else if (state_d == OVER) lives_d = '0;
      if (!pause_ev && frame_tick && bus.move_collision)
        score_d = SCORE_WIDTH'(sat_add(32'(score_q), 32'(bus.shift_amount), SCORE_WIDTH));
    end
  end

  assign bus.frame_tick = frame_tick;
  assign bus.game_state = state_q;
  assign bus.freeze     = freeze_q;
  assign bus.respawn    = respawn_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.high_score = hs_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a cycle reference model pushes the expected
// outputs into a queue after every clock edge; a monitor on the falling edge
// pops and compares. Directed phases plus a randomized phase drive inputs.
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  localparam int TICK_DIV = 10;
  localparam int T_LIVES  = 2;
  localparam int T_RESP   = 3;
  localparam int FALL_Y   = 768 - 80;
  localparam int SMAX     = 65535;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_sequencer_if #(.SCORE_WIDTH(16), .SHIFT_WIDTH(9)) bus ();

  game_sequencer #(
    .CLK            (3600),
    .FPS            (360),
    .LIVES          (T_LIVES),
    .RESPAWN_FRAMES (T_RESP),
    .SCORE_WIDTH    (16),
    .SHIFT_WIDTH    (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ft;
    logic [2:0]  st;
    logic        frz;
    logic        rsp;
    logic [3:0]  lv;
    logic [15:0] sc;
    logic [15:0] hs;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: k = clock edges since reset released.
  int          k       = 0;
  game_state_t m_st    = IDLE;
  int          m_lives = T_LIVES;
  int          m_score = 0;
  int          m_hs    = 0;
  int          m_rf    = 0;
  bit          m_rsp   = 0;
  bit          prev_s  = 0;
  bit          prev_p  = 0;

  function automatic obs_t model_obs();
    obs_t o;
    o.ft  = (k > 0) && (k % TICK_DIV == 0);
    o.st  = m_st;
    o.frz = (m_st != PLAY);
    o.rsp = m_rsp;
    o.lv  = 4'(m_lives);
    o.sc  = 16'(m_score);
    o.hs  = 16'(m_hs);
    return o;
  endfunction

  function automatic void model_step();
    bit tick, sev, pev;
    tick = (k > 0) && (k % TICK_DIV == 0);
    sev  = bus.start && !prev_s;
`ifdef GAME_PAUSE_EN
    pev  = bus.pause_toggle && !prev_p;
`else
    pev  = 1'b0;
`endif
    prev_s = bus.start;
    prev_p = bus.pause_toggle;
    k++;
    m_rsp = 0;
    if (m_st == OVER && m_score > m_hs) m_hs = m_score;
    case (m_st)
      IDLE, OVER: begin
        if (sev) begin
          m_st = PLAY; m_score = 0; m_lives = T_LIVES; m_rsp = 1;
        end
      end
      PLAY: begin
        if (pev) m_st = PAUSED;
        else begin
          if (tick && bus.move_collision) begin
            m_score = m_score + int'(bus.shift_amount);
            if (m_score > SMAX) m_score = SMAX;
          end
          if (tick && int'(bus.doodle_y) >= FALL_Y) begin
            if (m_lives > 1) begin m_lives--; m_rf = 0; m_st = RESPAWN; end
            else begin m_lives = 0; m_st = OVER; end
          end
        end
      end
      RESPAWN: begin
        if (tick) begin
          m_rf++;
          if (m_rf == T_RESP) begin m_st = PLAY; m_rsp = 1; end
        end
      end
      PAUSED: if (pev) m_st = PLAY;
      default: ;
    endcase
  endfunction

  // Reference model: one expected observation per clock edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0; m_st = IDLE; m_lives = T_LIVES; m_score = 0; m_hs = 0;
        m_rf = 0; m_rsp = 0; prev_s = 0; prev_p = 0;
      end else begin
        model_step();
      end
      exp_q.push_back(model_obs());
    end
  end

  // Monitor: compare every presented output set against the queued expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        a.ft  = bus.frame_tick;
        a.st  = bus.game_state;
        a.frz = bus.freeze;
        a.rsp = bus.respawn;
        a.lv  = bus.lives;
        a.sc  = bus.score;
        a.hs  = bus.high_score;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL scoreboard @%0t got ft=%0b st=%0d frz=%0b rsp=%0b lives=%0d score=%0d hs=%0d want ft=%0b st=%0d frz=%0b rsp=%0b lives=%0d score=%0d hs=%0d",
                   $time, a.ft, a.st, a.frz, a.rsp, a.lv, a.sc, a.hs,
                   e.ft, e.st, e.frz, e.rsp, e.lv, e.sc, e.hs);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ft"},     int'(bus.frame_tick), 0);
    check({tag, "_state"},  int'(bus.game_state), int'(IDLE));
    check({tag, "_freeze"}, int'(bus.freeze),     1);
    check({tag, "_resp"},   int'(bus.respawn),    0);
    check({tag, "_lives"},  int'(bus.lives),      T_LIVES);
    check({tag, "_score"},  int'(bus.score),      0);
    check({tag, "_hs"},     int'(bus.high_score), 0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int cnt;
    int guard;
    int r;
    bus.start = 0; bus.pause_toggle = 0; bus.doodle_y = 10'd100;
    bus.move_collision = 0; bus.shift_amount = '0;
    #1 rst = 1;
    #1 check_reset_values("reset");
    cyc(3);
    rst = 0;

    // Idle: ticks keep running, game stays frozen in IDLE.
    cnt = 0;
    repeat (50) begin cyc(1); cnt += int'(bus.frame_tick); end
    check("idle_ticks",  cnt, 5);
    check("idle_state",  int'(bus.game_state), int'(IDLE));
    check("idle_freeze", int'(bus.freeze), 1);
    check("idle_lives",  int'(bus.lives), T_LIVES);

    // Held start: exactly one transition and one respawn pulse.
    bus.start = 1;
    cnt = 0;
    repeat (20) begin cyc(1); cnt += int'(bus.respawn); end
    bus.start = 0;
    check("start_pulses", cnt, 1);
    check("start_state",  int'(bus.game_state), int'(PLAY));
    check("start_score",  int'(bus.score), 0);

    // Scoring: 4 frames of shift 10.
    bus.move_collision = 1; bus.shift_amount = 9'd10;
    cyc(40);
    check("score_40", int'(bus.score), 40);

    // Drive towards saturation.
    guard = 0;
    while (m_score + 511 < 65530 && guard < 500) begin
      bus.shift_amount = 9'd511; cyc(10); guard++;
    end
    bus.shift_amount = 9'(65530 - m_score);
    cyc(10);
    check("score_65530", int'(bus.score), 65530);
    bus.shift_amount = 9'd10;
    cyc(10);
    check("score_sat", int'(bus.score), SMAX);
    bus.shift_amount = 9'd511;
    cyc(10);
    check("score_sat_hold", int'(bus.score), SMAX);
    bus.move_collision = 0;

    // First fall: lose a life, respawn after T_RESP frames.
    bus.doodle_y = 10'(FALL_Y);
    cyc(10);
    bus.doodle_y = 10'd100;
    check("fall1_state", int'(bus.game_state), int'(RESPAWN));
    check("fall1_lives", int'(bus.lives), 1);
    cnt = 0;
    repeat (30) begin cyc(1); cnt += int'(bus.respawn); end
    check("respawn_pulses", cnt, 1);
    check("respawn_state",  int'(bus.game_state), int'(PLAY));

    // Second fall: game over, high score captured.
    bus.doodle_y = 10'd700;
    cyc(10);
    bus.doodle_y = 10'd100;
    cyc(2);
    check("over_state", int'(bus.game_state), int'(OVER));
    check("over_lives", int'(bus.lives), 0);
    check("over_hs",    int'(bus.high_score), SMAX);

    // Restart from OVER.
    bus.start = 1; cyc(1); bus.start = 0; cyc(1);
    check("restart_state", int'(bus.game_state), int'(PLAY));
    check("restart_score", int'(bus.score), 0);
    check("restart_hs",    int'(bus.high_score), SMAX);
    check("restart_lives", int'(bus.lives), T_LIVES);

`ifdef GAME_PAUSE_EN
    begin : pause_blk
      int frozen_sc;
      bus.move_collision = 1; bus.shift_amount = 9'd5;
      bus.pause_toggle = 1; cyc(1); bus.pause_toggle = 0;
      check("pause_enter", int'(bus.game_state), int'(PAUSED));
      frozen_sc = m_score;
      cyc(30);
      check("pause_frozen", int'(bus.score), frozen_sc);
      check("pause_freeze", int'(bus.freeze), 1);
      bus.pause_toggle = 1; cyc(1); bus.pause_toggle = 0; cyc(1);
      check("pause_exit", int'(bus.game_state), int'(PLAY));
      bus.start = 1; bus.pause_toggle = 1; cyc(1);
      bus.start = 0; bus.pause_toggle = 0; cyc(1);
      check("pause_wins", int'(bus.game_state), int'(PAUSED));
      bus.pause_toggle = 1; cyc(1); bus.pause_toggle = 0; cyc(1);
      check("pause_back", int'(bus.game_state), int'(PLAY));
      bus.move_collision = 0;
    end
`endif

    // Asynchronous reset in the middle of a respawn.
    bus.doodle_y = 10'(FALL_Y);
    cyc(10);
    bus.doodle_y = 10'd100;
    cyc(3);
    check("pre_rst_state", int'(bus.game_state), int'(RESPAWN));
    #4 rst = 1;
    #1 check_reset_values("async_rst");
    cyc(2);
    rst = 0;

    // Randomized play.
    repeat (800) begin
      bus.start          = ($urandom_range(0, 29) == 0);
      bus.pause_toggle   = ($urandom_range(0, 29) == 0);
      bus.move_collision = 1'($urandom_range(0, 1));
      bus.shift_amount   = 9'($urandom_range(0, 511));
      r = $urandom_range(0, 15);
      if (r == 0)      bus.doodle_y = 10'($urandom_range(FALL_Y - 2, FALL_Y + 1));
      else if (r == 1) bus.doodle_y = 10'($urandom_range(FALL_Y + 1, 1023));
      else             bus.doodle_y = 10'($urandom_range(0, FALL_Y - 3));
      cyc(1);
    end
    bus.start = 0; bus.pause_toggle = 0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
